// File: rtl/uart_frame_loader.sv
`timescale 1ns/1ps
// uart_frame_loader
// Pulls framed packets (SYNC, LEN_LO, LEN_HI, payload, CSUM) out of a UART
// byte receiver, writes the payload into the image RAM from address 0, and
// kicks the downsampler once the checksum matches.
// Optional inter-byte timeout: define UART_LOADER_TIMEOUT_EN.
module uart_frame_loader #(
    parameter int         ADDR_W      = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 500000
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              rx_ready_clr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              proc_busy,
    output logic              proc_start,
    output logic [15:0]       frame_len,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              loader_busy
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        PAYLOAD,
        CSUM,
        START
    } state_t;

    // Largest payload the RAM can hold; 17 bits so 2**16 fits.
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    state_t            state;
    logic              clr_hold;   // cycle after clr: receiver still shows ready
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [16:0]       count;      // payload bytes received so far
    logic [ADDR_W-1:0] addr;
    logic [7:0]        csum;

    logic              consume;
    logic [15:0]       len_rx;
    logic              to_hit;

    // A byte is taken only when the receiver holds it and we are not still
    // inside our own clear/settle window. START leaves the byte pending.
    assign consume = rx_ready && !rx_ready_clr && !clr_hold && (state != START);
    assign len_rx  = {rx_data, len_lo};

`ifdef UART_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;
    logic            in_frame;

    assign in_frame = (state == LEN_LO) || (state == LEN_HI) ||
                      (state == PAYLOAD) || (state == CSUM);
    assign to_hit   = in_frame && !consume && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Inter-byte silence counter; restarts on every byte and outside a frame.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!in_frame || consume || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Frame parser, handshake and all registered outputs.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rx_ready_clr <= 1'b0;
            clr_hold     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            proc_start   <= 1'b0;
            frame_len    <= '0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            err_code     <= 2'b00;
            loader_busy  <= 1'b0;
            len_lo       <= '0;
            len          <= '0;
            count        <= '0;
            addr         <= '0;
            csum         <= '0;
        end else begin
            rx_ready_clr <= consume;
            clr_hold     <= rx_ready_clr;
            mem_we       <= 1'b0;
            proc_start   <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;

            if (to_hit) begin
                frame_err   <= 1'b1;
                err_code    <= 2'b11;
                state       <= IDLE;
                loader_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (consume && rx_data == SYNC_BYTE && !proc_busy) begin
                            csum        <= '0;
                            err_code    <= 2'b00;
                            state       <= LEN_LO;
                            loader_busy <= 1'b1;
                        end
                    end
                    LEN_LO: begin
                        if (consume) begin
                            len_lo <= rx_data;
                            csum   <= csum ^ rx_data;
                            state  <= LEN_HI;
                        end
                    end
                    LEN_HI: begin
                        if (consume) begin
                            csum <= csum ^ rx_data;
                            if (len_rx == 16'd0 || {1'b0, len_rx} > MAX_LEN) begin
                                frame_err   <= 1'b1;
                                err_code    <= 2'b01;
                                state       <= IDLE;
                                loader_busy <= 1'b0;
                            end else begin
                                len   <= len_rx;
                                addr  <= '0;
                                count <= '0;
                                state <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (consume) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= rx_data;
                            mem_addr  <= addr;
                            addr      <= addr + 1'b1;
                            csum      <= csum ^ rx_data;
                            count     <= count + 17'd1;
                            if (count + 17'd1 == {1'b0, len}) begin
                                state <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (consume) begin
                            if (rx_data == csum) begin
                                state <= START;
                            end else begin
                                frame_err   <= 1'b1;
                                err_code    <= 2'b10;
                                state       <= IDLE;
                                loader_busy <= 1'b0;
                            end
                        end
                    end
                    START: begin
                        if (!proc_busy) begin
                            proc_start  <= 1'b1;
                            frame_done  <= 1'b1;
                            frame_len   <= len;
                            state       <= IDLE;
                            loader_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        loader_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
`timescale 1ns/1ps
// Bench for uart_frame_loader: randomized frames driven through a receiver
// model, compared against expectations derived from the frame format.
module tb_uart_frame_loader;

    localparam int ADDR_W  = 6;
    localparam int MAXLEN  = 1 << ADDR_W;
    localparam int TIMEOUT = 100;

    logic              clk_50m   = 1'b0;
    logic              rst_n     = 1'b1;
    logic [7:0]        rx_data   = 8'h00;
    logic              rx_ready  = 1'b0;
    logic              proc_busy = 1'b0;
    logic              rx_ready_clr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              proc_start;
    logic [15:0]       frame_len;
    logic              frame_done;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              loader_busy;

    uart_frame_loader #(
        .ADDR_W      (ADDR_W),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk_50m      (clk_50m),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_ready_clr (rx_ready_clr),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .proc_busy    (proc_busy),
        .proc_start   (proc_start),
        .frame_len    (frame_len),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .loader_busy  (loader_busy)
    );

    always #10 clk_50m = ~clk_50m;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event monitor: everything the DUT does, sampled mid-cycle.
    int wr_addr_q[$];
    int wr_data_q[$];
    int n_start = 0;
    int n_done  = 0;
    int n_err   = 0;
    int n_clr   = 0;

    always @(negedge clk_50m) begin
        if (rst_n) begin
            if (mem_we) begin
                wr_addr_q.push_back(int'(mem_addr));
                wr_data_q.push_back(int'(mem_wdata));
            end
            if (proc_start) n_start++;
            if (frame_done) n_done++;
            if (frame_err)  n_err++;
            if (rx_ready_clr) n_clr++;
        end
    end

    // Receiver model: present a byte, hold until cleared plus one cycle.
    task automatic send_byte(input logic [7:0] b);
        int budget;
        repeat ($urandom_range(1, 3)) @(negedge clk_50m);
        rx_data  = b;
        rx_ready = 1'b1;
        budget   = 0;
        do begin
            @(negedge clk_50m);
            budget++;
        end while (!rx_ready_clr && budget < 2000);
        if (!rx_ready_clr) check("handshake_wait", 0, 1);
        @(negedge clk_50m);
        @(negedge clk_50m);
        rx_ready = 1'b0;
    endtask

    logic [7:0] pay [MAXLEN];
    int exp_frame_len = 0;

    // One frame built from the format rules; expectations come straight
    // from the length field, the payload and the XOR checksum.
    task automatic run_frame(input string tag, input int len, input bit bad_csum, input int garbage);
        int b_clr, b_wr, b_st, b_dn, b_er, sent, exp_wr, exp_ok, exp_err, got_wr;
        logic [7:0] lo, hi, x, g;
        bit len_bad;
        b_clr = n_clr; b_wr = wr_addr_q.size(); b_st = n_start; b_dn = n_done; b_er = n_err;
        lo = 8'(len);
        hi = 8'(len >> 8);
        len_bad = (len == 0) || (len > MAXLEN);
        sent = 0;
        for (int i = 0; i < garbage; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            send_byte(g);
            sent++;
        end
        send_byte(8'hA5);
        send_byte(lo);
        send_byte(hi);
        sent += 3;
        x = lo ^ hi;
        if (!len_bad) begin
            for (int i = 0; i < len; i++) begin
                send_byte(pay[i]);
                x ^= pay[i];
            end
            if (bad_csum) x ^= 8'($urandom_range(1, 255));
            send_byte(x);
            sent += len + 1;
        end
        repeat (8) @(negedge clk_50m);
        exp_wr  = len_bad ? 0 : len;
        exp_ok  = (!len_bad && !bad_csum) ? 1 : 0;
        exp_err = len_bad ? 1 : (bad_csum ? 2 : 0);
        if (exp_ok == 1) exp_frame_len = len;
        got_wr = wr_addr_q.size() - b_wr;
        check({tag, " consumed"}, n_clr - b_clr, sent);
        check({tag, " writes"}, got_wr, exp_wr);
        for (int i = 0; i < exp_wr; i++) begin
            if (i < got_wr) begin
                check({tag, " wr_addr"}, wr_addr_q[b_wr + i], i);
                check({tag, " wr_data"}, wr_data_q[b_wr + i], int'(pay[i]));
            end
        end
        check({tag, " starts"}, n_start - b_st, exp_ok);
        check({tag, " done"}, n_done - b_dn, exp_ok);
        check({tag, " err_pulse"}, n_err - b_er, 1 - exp_ok);
        check({tag, " err_code"}, err_code, exp_err);
        check({tag, " frame_len"}, frame_len, exp_frame_len);
        check({tag, " busy"}, loader_busy, 0);
        $display("frame %s len=%0d bad_csum=%0d garbage=%0d writes=%0d err_code=%0d",
                 tag, len, bad_csum, garbage, got_wr, err_code);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_clr, b_wr, b_st, b_dn, b_er, len, kind, budget;
        logic [7:0] x;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk_50m);
        check("reset outputs", {rx_ready_clr, mem_we, mem_addr, mem_wdata, proc_start,
                                frame_len, frame_done, frame_err, err_code, loader_busy}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50m);

        // Directed frames.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        run_frame("good4", 4, 1'b0, 0);
        run_frame("badcsum4", 4, 1'b1, 0);
        run_frame("len0", 0, 1'b0, 0);
        run_frame("after_len0", 4, 1'b0, 1);
        run_frame("len_over", MAXLEN + 1, 1'b0, 0);
        for (int i = 0; i < MAXLEN; i++) pay[i] = 8'($urandom);
        run_frame("len_max", MAXLEN, 1'b0, 0);
        run_frame("len1", 1, 1'b0, 2);

        // proc_busy held across CSUM delays the start.
        b_st = n_start; b_dn = n_done;
        pay[0] = 8'h3C; pay[1] = 8'hC3;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(pay[0]); send_byte(pay[1]);
        proc_busy = 1'b1;
        send_byte(8'h02 ^ 8'h3C ^ 8'hC3);
        repeat (10) @(negedge clk_50m);
        check("busy_hold starts", n_start - b_st, 0);
        check("busy_hold loader_busy", loader_busy, 1);
        proc_busy = 1'b0;
        repeat (4) @(negedge clk_50m);
        check("busy_release starts", n_start - b_st, 1);
        check("busy_release done", n_done - b_dn, 1);
        check("busy_release frame_len", frame_len, 2);
        exp_frame_len = 2;
        $display("busy-at-csum frame: starts=%0d frame_len=%0d", n_start - b_st, frame_len);

        // SYNC while the downsampler is busy is dropped.
        b_clr = n_clr;
        proc_busy = 1'b1;
        send_byte(8'hA5);
        repeat (3) @(negedge clk_50m);
        check("sync_busy consumed", n_clr - b_clr, 1);
        check("sync_busy loader_busy", loader_busy, 0);
        proc_busy = 1'b0;
        $display("sync while busy: loader_busy=%0d", loader_busy);
        pay[0] = 8'h5A; pay[1] = 8'hA5; pay[2] = 8'h00;
        run_frame("after_drop", 3, 1'b0, 0);

        // rx_ready held three cycles: one clear, one byte.
        b_clr = n_clr; b_wr = wr_addr_q.size(); b_st = n_start;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        @(negedge clk_50m);
        rx_data = 8'h5A; rx_ready = 1'b1;
        repeat (3) @(negedge clk_50m);
        rx_ready = 1'b0;
        check("hold3 clr_count", n_clr - b_clr, 4);
        check("hold3 writes", wr_addr_q.size() - b_wr, 1);
        send_byte(8'h3C);
        send_byte(8'h02 ^ 8'h5A ^ 8'h3C);
        repeat (8) @(negedge clk_50m);
        check("hold3 total_writes", wr_addr_q.size() - b_wr, 2);
        check("hold3 starts", n_start - b_st, 1);
        exp_frame_len = 2;
        $display("hold3 handshake: clr_total=%0d writes=%0d", n_clr - b_clr, wr_addr_q.size() - b_wr);

`ifdef UART_LOADER_TIMEOUT_EN
        // Silence mid-payload aborts the frame.
        b_wr = wr_addr_q.size(); b_er = n_err;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h11);
        budget = 0;
        while (n_err == b_er && budget < 3 * TIMEOUT) begin
            @(negedge clk_50m);
            budget++;
        end
        check("timeout err_pulse", n_err - b_er, 1);
        check("timeout err_code", err_code, 3);
        check("timeout loader_busy", loader_busy, 0);
        check("timeout writes", wr_addr_q.size() - b_wr, 1);
        $display("timeout frame: err_code=%0d after %0d cycles", err_code, budget);
`else
        // Without the timeout the loader waits indefinitely mid-frame.
        b_st = n_start; b_er = n_err;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        budget = 0;
        repeat (3 * TIMEOUT) begin
            @(negedge clk_50m);
            budget++;
        end
        check("notimeout loader_busy", loader_busy, 1);
        check("notimeout err_pulse", n_err - b_er, 0);
        send_byte(8'h77);
        send_byte(8'h01 ^ 8'h77);
        repeat (8) @(negedge clk_50m);
        check("notimeout starts", n_start - b_st, 1);
        exp_frame_len = 1;
        $display("long gap frame: idle=%0d cycles starts=%0d", budget, n_start - b_st);
`endif

        // Reset in the middle of a payload.
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        repeat (2) @(negedge clk_50m);
        #3 rst_n = 1'b0;
        #1;
        check("midreset outputs", {rx_ready_clr, mem_we, mem_addr, mem_wdata, proc_start,
                                   frame_len, frame_done, frame_err, err_code, loader_busy}, 0);
        $display("mid-payload reset: loader_busy=%0d frame_len=%0d", loader_busy, frame_len);
        @(negedge clk_50m);
        rst_n = 1'b1;
        exp_frame_len = 0;
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        run_frame("after_reset", 4, 1'b0, 0);

        // Randomized frames.
        for (int f = 0; f < 20; f++) begin
            kind = $urandom_range(0, 5);
            if ($urandom_range(0, 7) == 0) len = MAXLEN;
            else len = $urandom_range(1, 12);
            for (int i = 0; i < MAXLEN; i++) pay[i] = 8'($urandom);
            case (kind)
                0:       run_frame("rand_len0", 0, 1'b0, $urandom_range(0, 2));
                1:       run_frame("rand_over", $urandom_range(MAXLEN + 1, 1000), 1'b0, $urandom_range(0, 2));
                2:       run_frame("rand_badcsum", len, 1'b1, $urandom_range(0, 2));
                default: run_frame("rand_good", len, 1'b0, $urandom_range(0, 2));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
